// File: rtl/axi_chan_buf.sv
// axi_chan_buf: valid/ready buffer for one packed AXI channel bundle, with optional fall-through and packet modes
module axi_chan_buf #(
  parameter int DATA_W      = 64,
  parameter int DEPTH       = 4,
  parameter int FALLTHROUGH = 0,
  parameter int PKT_MODE    = 0,
  parameter int LAST_BIT    = 0,
  parameter int AFULL_TH    = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_W-1:0]            s_payload,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_W-1:0]            m_payload,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full,
  output logic                         pkt_forced
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C = CW'(AFULL_TH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] pkt_cnt, count_next;
  logic rel_q, rel, empty, full, bypass, push, pop, wr_en, rd_en, last_out;
  if (PKT_MODE != 0 && FALLTHROUGH != 0) begin : g_illegal
    $error("axi_chan_buf: PKT_MODE and FALLTHROUGH cannot both be set");
  end
  always_comb begin
    empty = count == '0;
    full = count == FULL_C;
    bypass = FALLTHROUGH != 0 && empty;
    rel = rel_q | (full & (pkt_cnt == '0));
    pkt_forced = PKT_MODE != 0 && full && pkt_cnt == '0 && !rel_q;
    m_valid = bypass ? (s_valid & s_ready) : (!empty && (PKT_MODE == 0 || pkt_cnt != '0 || rel));
    m_payload = !empty ? mem[rd_ptr] : (bypass && s_ready) ? s_payload : '0;
    push = s_valid & s_ready;
    pop = m_valid & m_ready;
    wr_en = push & ~(bypass & pop);
    rd_en = pop & ~bypass;
    last_out = rd_en & m_payload[LAST_BIT];
    count_next = count + CW'(wr_en) - CW'(rd_en);
    almost_full = count >= AF_C;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      pkt_cnt <= '0;
      s_ready <= 1'b0;
      rel_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
      s_ready <= count_next < FULL_C;
      if (PKT_MODE != 0) begin
        pkt_cnt <= pkt_cnt + CW'(wr_en & s_payload[LAST_BIT]) - CW'(last_out);
        rel_q <= rel & ~last_out;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr] <= s_payload;
  end
endmodule

// File: tb/tb_axi_chan_buf.sv
// tb_axi_chan_buf: three buffer flavours (plain, fall-through, packet) checked against a queue model every cycle
module tb_axi_chan_buf;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rs [3], sv [3], mr [3], srdy [3], mv [3], af [3], pf [3];
  logic [15:0] sp [3], mp [3];
  logic [2:0] cnt [3];
  logic [15:0] mb [3][4];
  int hd [3], sz [3];
  logic srd [3], rel [3];
  bit chk_en = 0, m_push, m_pop, m_lo, m_cond;
  int n_cmp = 0, n_bad = 0;
  axi_chan_buf #(.DATA_W(16)) u0 (.clk(clk), .rst(rs[0]), .s_valid(sv[0]), .s_ready(srdy[0]),
    .s_payload(sp[0]), .m_valid(mv[0]), .m_ready(mr[0]), .m_payload(mp[0]), .count(cnt[0]),
    .almost_full(af[0]), .pkt_forced(pf[0]));
  axi_chan_buf #(.DATA_W(16), .FALLTHROUGH(1)) u1 (.clk(clk), .rst(rs[1]), .s_valid(sv[1]),
    .s_ready(srdy[1]), .s_payload(sp[1]), .m_valid(mv[1]), .m_ready(mr[1]), .m_payload(mp[1]),
    .count(cnt[1]), .almost_full(af[1]), .pkt_forced(pf[1]));
  axi_chan_buf #(.DATA_W(16), .PKT_MODE(1), .LAST_BIT(0)) u2 (.clk(clk), .rst(rs[2]), .s_valid(sv[2]),
    .s_ready(srdy[2]), .s_payload(sp[2]), .m_valid(mv[2]), .m_ready(mr[2]), .m_payload(mp[2]),
    .count(cnt[2]), .almost_full(af[2]), .pkt_forced(pf[2]));
  function automatic bit has_last(int i);
    for (int k = 0; k < sz[i]; k++) if (mb[i][(hd[i] + k) % 4][0]) return 1'b1;
    return 1'b0;
  endfunction
  function automatic bit e_mv(int i);
    if (sz[i] == 0) return (i == 1) ? (sv[i] & srd[i]) : 1'b0;
    if (i != 2) return 1'b1;
    return has_last(i) || rel[i] || sz[i] == 4;
  endfunction
  function automatic bit e_pf(int i);
    return i == 2 && sz[i] == 4 && !has_last(i) && !rel[i];
  endfunction
  function automatic logic [15:0] e_pl(int i);
    return sz[i] > 0 ? mb[i][hd[i]] : (i == 1 && srd[i]) ? sp[i] : 16'h0;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rs[i]) begin
        sz[i] = 0; hd[i] = 0; srd[i] = 1'b0; rel[i] = 1'b0;
      end else begin
        m_push = sv[i] & srd[i];
        m_pop = e_mv(i) & mr[i];
        m_lo = m_pop && sz[i] > 0 && mb[i][hd[i]][0];
        m_cond = sz[i] == 4 && !has_last(i);
        if (i == 2) rel[i] = (rel[i] | m_cond) & !m_lo;
        if (m_pop && sz[i] > 0) begin
          hd[i] = (hd[i] + 1) % 4;
          sz[i]--;
        end else if (m_pop) m_push = 1'b0;
        if (m_push) begin
          mb[i][(hd[i] + sz[i]) % 4] = sp[i];
          sz[i]++;
        end
        srd[i] = sz[i] < 4;
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("m_valid%0d", i), 32'(mv[i]), 32'(e_mv(i)));
        chk($sformatf("s_ready%0d", i), 32'(srdy[i]), 32'(srd[i]));
        chk($sformatf("count%0d", i), 32'(cnt[i]), 32'(sz[i]));
        chk($sformatf("almost_full%0d", i), 32'(af[i]), 32'(sz[i] >= 3));
        chk($sformatf("pkt_forced%0d", i), 32'(pf[i]), 32'(e_pf(i)));
        if (i != 1 || e_mv(i)) chk($sformatf("m_payload%0d", i), 32'(mp[i]), 32'(e_pl(i)));
      end
    end
  end
  initial begin
    for (int i = 0; i < 3; i++) begin
      rs[i] = 1'b1; sv[i] = 1'b0; mr[i] = 1'b0; sp[i] = 16'h0;
    end
    tick();
    chk("rst_count", 32'(cnt[0]), 0);
    chk("rst_s_ready", 32'(srdy[0]), 0);
    chk("rst_m_valid", 32'(mv[0]), 0);
    chk("rst_payload", 32'(mp[0]), 0);
    chk_en = 1;
    for (int i = 0; i < 3; i++) rs[i] = 1'b0;
    tick();
    chk("s_ready_after_rst", 32'(srdy[0]), 1);
    for (int k = 0; k < 4; k++) begin
      sv[0] = 1'b1; sp[0] = 16'(16'hA0 + k);
      tick();
    end
    sv[0] = 1'b0;
    chk("t1_count", 32'(cnt[0]), 4);
    chk("t1_s_ready", 32'(srdy[0]), 0);
    chk("t1_payload", 32'(mp[0]), 32'hA0);
    chk("t1_afull", 32'(af[0]), 1);
    mr[0] = 1'b1;
    tick();
    chk("t2_count", 32'(cnt[0]), 3);
    chk("t2_s_ready", 32'(srdy[0]), 1);
    sv[0] = 1'b1; sp[0] = 16'hA4;
    tick();
    sv[0] = 1'b0;
    chk("t2_count_pushpop", 32'(cnt[0]), 3);
    for (int k = 2; k < 5; k++) begin
      chk("t2_order", 32'(mp[0]), 32'(16'hA0 + k));
      tick();
    end
    mr[0] = 1'b0;
    chk("t2_empty", 32'(cnt[0]), 0);
    sv[1] = 1'b1; sp[1] = 16'h55; mr[1] = 1'b1;
    #1;
    chk("t3_m_valid", 32'(mv[1]), 1);
    chk("t3_payload", 32'(mp[1]), 32'h55);
    tick();
    chk("t3_count", 32'(cnt[1]), 0);
    sv[1] = 1'b0; mr[1] = 1'b0;
    mr[2] = 1'b1; sv[2] = 1'b1;
    sp[2] = 16'h2; tick();
    chk("t4_hold_a", 32'(mv[2]), 0);
    sp[2] = 16'h4; tick();
    chk("t4_hold_b", 32'(mv[2]), 0);
    sp[2] = 16'h7; tick();
    sv[2] = 1'b0;
    chk("t4_release", 32'(mv[2]), 1);
    chk("t4_out_a", 32'(mp[2]), 32'h2);
    tick();
    chk("t4_out_b", 32'(mp[2]), 32'h4);
    tick();
    chk("t4_out_c", 32'(mp[2]), 32'h7);
    tick();
    chk("t4_drained", 32'(cnt[2]), 0);
    mr[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sv[2] = 1'b1; sp[2] = 16'(16'h10 + 2 * k);
      tick();
    end
    sv[2] = 1'b0;
    chk("t5_forced", 32'(pf[2]), 1);
    chk("t5_m_valid", 32'(mv[2]), 1);
    tick();
    chk("t5_pulse_end", 32'(pf[2]), 0);
    chk("t5_held", 32'(mv[2]), 1);
    mr[2] = 1'b1;
    repeat (4) tick();
    chk("t5_drained", 32'(cnt[2]), 0);
    mr[2] = 1'b0;
    repeat (3) begin
      sv[0] = 1'b1; sp[0] = 16'($urandom);
      tick();
    end
    sv[0] = 1'b0;
    chk("t6_pre", 32'(cnt[0]), 3);
    for (int i = 0; i < 3; i++) rs[i] = 1'b1;
    tick();
    chk("t6_count", 32'(cnt[0]), 0);
    chk("t6_m_valid", 32'(mv[0]), 0);
    chk("t6_s_ready", 32'(srdy[0]), 0);
    for (int i = 0; i < 3; i++) rs[i] = 1'b0;
    tick();
    chk("t6_s_ready_next", 32'(srdy[0]), 1);
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 3; i++) begin
        rs[i] = $urandom_range(0, 999) == 0;
        sv[i] = $urandom_range(0, 3) != 0;
        mr[i] = ((c / 500) % 2 == 0) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) < 2);
        sp[i] = 16'($urandom);
        if (i == 2) sp[i][0] = $urandom_range(0, 3) == 0;
      end
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
